dm_copy_engine: RTL and testbench
=================================

Name: dm_copy_engine

Overview:
Bus-initiator for the data-memory port (m_data_addr / m_data_rdata / m_data_wdata / m_data_byteen) that the CPU M stage also drives; the memory model is the responder. Copies a byte-length block from a word-aligned source to a word-aligned destination, one word per read/write pair. The tail word is written with a partial little-endian byte enable. It is used for memory preload and memcpy in the pipeline test environment.

Parameters:
LEN_W, 16, width of the byte-length operand
IDLE_ADDR, 32'h0000_0000, value driven on m_data_addr when not accessing memory

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request pulse; sampled only in IDLE
src_addr  input  32  source byte address; must be word-aligned
dst_addr  input  32  destination byte address; must be word-aligned
len  input  LEN_W  number of bytes to copy
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse, coincident with done, on misaligned src/dst
m_data_addr  output  32  memory address, word-aligned
m_data_rdata  input  32  memory read data; combinational with m_data_addr in the same cycle
m_data_wdata  output  32  memory write data
m_data_byteen  output  4  byte enables; bit i writes wdata[8i+7:8i]; a write commits on the next posedge when the value is nonzero

Behaviour:
- Reset (reset=0, asynchronous) puts the block in IDLE. While in reset: busy=0, done=0, err=0, m_data_addr=IDLE_ADDR, m_data_wdata=0, m_data_byteen=0. All of these are registered or decoded from state, so byteen drops immediately when reset asserts.
- States: IDLE, READ, WRITE, FIN.
- IDLE, start=1:
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0: go to FIN with the err flag latched.
  - Else if len==0: go to FIN.
  - Else: latch src_ptr, dst_ptr, rem=len; go to READ.
- IDLE, start=0: stay in IDLE.
- READ: m_data_addr=src_ptr, byteen=0. At the posedge, capture m_data_rdata into buf; go to WRITE.
- WRITE: m_data_addr=dst_ptr, m_data_wdata=buf.
  - byteen by rem: rem>=4 → 4'b1111; rem=3 → 4'b0111; rem=2 → 4'b0011; rem=1 → 4'b0001.
  - At the posedge: src_ptr+=4, dst_ptr+=4, rem = (rem>=4) ? rem-4 : 0.
  - If the new rem==0, go to FIN; else go to READ.
- FIN: done=1 (err=1 if latched) for exactly one cycle; clear err flag; go to IDLE.
- Latency: start to done = 2*ceil(len/4)+1 cycles. Zero-length or error requests finish in 1 cycle with no memory access, and byteen never goes nonzero.
- start while busy is ignored; operands are not re-latched.
- Pointers wrap modulo 2^32. No range check is done. Overlapping regions copy forward, word by word.
- Reset mid-operation aborts the copy. Words already committed stay written, and no done pulse is produced.

Optional Feature:
Macro DM_COPY_FILL_EN.
- Defined: adds ports fill (input, 1) and fill_word (input, 32).
  - start with fill=1 skips READ entirely: buf=fill_word, state goes straight to WRITE.
  - Consecutive WRITE cycles run back-to-back, one word per cycle, with the same tail masking.
  - Latency is ceil(len/4)+1 cycles. src_addr is ignored, and only dst alignment can raise err.
- Undefined: the ports are absent and the block does copy only.

Decomposition:
- Package dm_copy_pkg holds:
  - the state encoding (IDLE/READ/WRITE/FIN);
  - BYTEEN_FULL=4'b1111 and BYTEEN_NONE=4'b0000;
  - a tail-mask function mapping rem[LEN_W-1:0] to 4-bit byteen.
- No sub-module is required; the tail mask is a package function, not an instance.

Test Plan:
- Memory preload: 0x0=11223344, 0x4=AABBCCDD. Request src=0, dst=0x100, len=8. Expected: writes *00000100<=11223344 then *00000104<=aabbccdd, both with byteen=1111; done 5 cycles after start; err=0.
- Same source, 0x204 preset to FFFFFFFF. Request dst=0x200, len=6. Expected: second write has byteen=0011; 0x204 ends as FFFFCCDD; done at 5 cycles.
- Request len=0. Expected: done 1 cycle later, err=0, byteen stays 0000 throughout.
- Request src=0x2 (also dst=0x101, separately). Expected: done and err pulse together 1 cycle after start; no memory writes; busy high for 1 cycle.
- Start a 16-byte copy, then pull reset low during the second WRITE. Expected: byteen=0 in the same cycle, busy=0, no further writes and no done. After release, a fresh len=4 copy completes normally in 3 cycles.
- Pulse start with different operands while busy. Expected: ignored; the original copy completes unchanged.
- With DM_COPY_FILL_EN: fill=1, fill_word=DEADBEEF, dst=0x300, len=12. Expected: three writes on consecutive cycles with byteen=1111; done 4 cycles after start.

Source files
------------

// File: rtl/dm_copy_pkg.sv
// rtl/dm_copy_pkg.sv - shared types, byte-enable constants and tail-mask helper for dm_copy_engine
package dm_copy_pkg;

  localparam int DM_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [3:0] BYTEEN_FULL = 4'b1111;
  localparam logic [3:0] BYTEEN_NONE = 4'b0000;

  // Little-endian byte enable for the word being written, given the bytes still owed.
  function automatic logic [3:0] tail_mask(input logic [31:0] rem);
    logic [3:0] mask;
    mask = BYTEEN_NONE;
    if (rem >= 32'd4) begin
      mask = BYTEEN_FULL;
    end else begin
      case (rem[1:0])
        2'd3:    mask = 4'b0111;
        2'd2:    mask = 4'b0011;
        2'd1:    mask = 4'b0001;
        default: mask = BYTEEN_NONE;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/dm_copy_engine.sv
// rtl/dm_copy_engine.sv - word-at-a-time block copy initiator on the data-memory port (optional fill mode: DM_COPY_FILL_EN)
module dm_copy_engine
  import dm_copy_pkg::*;
#(
  parameter int          LEN_W     = DM_LEN_W,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef DM_COPY_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_word,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      m_data_addr,
  input  logic [31:0]      m_data_rdata,
  output logic [31:0]      m_data_wdata,
  output logic [3:0]       m_data_byteen
);

  state_t           state;
  state_t           next_state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_next;
  logic [31:0]      data_buf;
  logic             err_flag;
  logic             fill_mode;
  logic             req_fill;
  logic             req_bad;

`ifdef DM_COPY_FILL_EN
  assign req_fill = fill;
`else
  assign req_fill = 1'b0;
`endif

  // A fill request never reads, so its source alignment is irrelevant.
  assign req_bad  = ((src_addr[1:0] != 2'b00) && !req_fill) || (dst_addr[1:0] != 2'b00);

  // Bytes still owed after the current write; the tail word clamps to zero.
  assign rem_next = (rem >= LEN_W'(4)) ? (rem - LEN_W'(4)) : '0;

  // State register; reset lands in IDLE so all decoded outputs drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and memory-port decode.
  always_comb begin
    next_state    = state;
    busy          = (state != ST_IDLE);
    done          = 1'b0;
    err           = 1'b0;
    m_data_addr   = IDLE_ADDR;
    m_data_wdata  = 32'h0;
    m_data_byteen = BYTEEN_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (req_bad || (len == '0)) begin
            next_state = ST_FIN;
          end else if (req_fill) begin
            next_state = ST_WRITE;
          end else begin
            next_state = ST_READ;
          end
        end
      end
      ST_READ: begin
        m_data_addr = src_ptr;
        next_state  = ST_WRITE;
      end
      ST_WRITE: begin
        m_data_addr   = dst_ptr;
        m_data_wdata  = data_buf;
        m_data_byteen = tail_mask(32'(rem));
        if (rem_next == '0) begin
          next_state = ST_FIN;
        end else if (fill_mode) begin
          next_state = ST_WRITE;
        end else begin
          next_state = ST_READ;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        err        = err_flag;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand latch, read-data capture and pointer/remaining-count advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_ptr   <= 32'h0;
      dst_ptr   <= 32'h0;
      rem       <= '0;
      data_buf  <= 32'h0;
      err_flag  <= 1'b0;
      fill_mode <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_flag <= req_bad;
            if (!req_bad && (len != '0)) begin
              src_ptr   <= src_addr;
              dst_ptr   <= dst_addr;
              rem       <= len;
              fill_mode <= req_fill;
`ifdef DM_COPY_FILL_EN
              if (fill) begin
                data_buf <= fill_word;
              end
`endif
            end
          end
        end
        ST_READ: begin
          data_buf <= m_data_rdata;
        end
        ST_WRITE: begin
          src_ptr <= src_ptr + 32'd4;
          dst_ptr <= dst_ptr + 32'd4;
          rem     <= rem_next;
        end
        ST_FIN: begin
          err_flag  <= 1'b0;
          fill_mode <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_copy_engine.sv
// tb/tb_dm_copy_engine.sv - self-checking bench for dm_copy_engine with memory responder and byte-level model
module tb_dm_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_rdata;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
`ifdef DM_COPY_FILL_EN
  logic        fill;
  logic [31:0] fill_word;
`endif

  always #5 clk = ~clk;

  dm_copy_engine #(.LEN_W(16), .IDLE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
`ifdef DM_COPY_FILL_EN
    .fill         (fill),
    .fill_word    (fill_word),
`endif
    .busy         (busy),
    .done         (done),
    .err          (err),
    .m_data_addr  (m_data_addr),
    .m_data_rdata (m_data_rdata),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen)
  );

  // Responder memory (1 KiB, address bits above 9 ignored) plus write log.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;
  int          wr_count = 0;
  int          done_count = 0;
  int          cyc = 0;
  logic [31:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic [3:0]  log_be   [0:255];
  int          log_cyc  [0:255];

  assign m_data_rdata = mem[m_data_addr[9:2]];

  // Memory commits on posedge whenever byteen is nonzero; every commit is logged.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_data;
    if (m_data_byteen != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b]) mem[m_data_addr[9:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
      log_addr[wr_count[7:0]] <= m_data_addr;
      log_data[wr_count[7:0]] <= m_data_wdata;
      log_be[wr_count[7:0]]   <= m_data_byteen;
      log_cyc[wr_count[7:0]]  <= cyc;
      wr_count <= wr_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  logic [7:0] model [0:1023];
  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) model[(a + 32'(b)) & 32'h3FF] = d[8*b +: 8];
    pl_idx = a[9:2]; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    logic [31:0] w;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {model[4*i+3], model[4*i+2], model[4*i+1], model[4*i]};
      if (mem[i] !== w) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_done(output int cycles, output logic e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    e = err;
    @(posedge clk); #1;
  endtask

  // One request checked against latency, flag, write-count and final memory image.
  task automatic do_op(input string tag, input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic f, input logic [31:0] fw);
    logic bad;
    int words, exp_cyc, exp_wr, wc0, dc0, cycles;
    logic e;
    bad = ((s[1:0] != 2'b00) && !f) || (d[1:0] != 2'b00);
    words = (n + 3) / 4;
    exp_cyc = (bad || n == 0) ? 1 : (f ? words + 1 : 2 * words + 1);
    exp_wr = (bad || n == 0) ? 0 : words;
    wc0 = wr_count; dc0 = done_count;
    src_addr = s; dst_addr = d; len = 16'(n);
`ifdef DM_COPY_FILL_EN
    fill = f; fill_word = fw;
`endif
    wait_done(cycles, e);
`ifdef DM_COPY_FILL_EN
    fill = 1'b0;
`endif
    check({tag, " latency"}, 32'(cycles), 32'(exp_cyc));
    check({tag, " err"}, {31'h0, e}, {31'h0, bad});
    check({tag, " writes"}, 32'(wr_count - wc0), 32'(exp_wr));
    check({tag, " done pulses"}, 32'(done_count - dc0), 32'd1);
    if (!bad) begin
      for (int b = 0; b < n; b++)
        model[(d + 32'(b)) & 32'h3FF] = f ? fw[8*(b%4) +: 8] : model[(s + 32'(b)) & 32'h3FF];
    end
    check_mem({tag, " memory"});
  endtask

  initial begin
    int wc0, dc0, cycles;
    logic [31:0] s, d;
    logic f;
    reset = 1'b0; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len = 16'h0;
`ifdef DM_COPY_FILL_EN
    fill = 1'b0; fill_word = 32'h0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst done", {31'h0, done}, 32'h0);
    check("rst err", {31'h0, err}, 32'h0);
    check("rst addr", m_data_addr, 32'h0);
    check("rst wdata", m_data_wdata, 32'h0);
    check("rst byteen", {28'h0, m_data_byteen}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);

    // Preload-style copy: two full words.
    preload(32'h0, 32'h1122_3344);
    preload(32'h4, 32'hAABB_CCDD);
    wc0 = wr_count;
    do_op("copy8", 32'h0, 32'h100, 8, 1'b0, 32'h0);
    check("copy8 w0 addr", log_addr[wc0[7:0]], 32'h100);
    check("copy8 w0 data", log_data[wc0[7:0]], 32'h1122_3344);
    check("copy8 w0 be", {28'h0, log_be[wc0[7:0]]}, 32'hF);
    check("copy8 w1 addr", log_addr[8'(wc0 + 1)], 32'h104);
    check("copy8 w1 data", log_data[8'(wc0 + 1)], 32'hAABB_CCDD);
    check("copy8 w1 be", {28'h0, log_be[8'(wc0 + 1)]}, 32'hF);

    // Tail word masked to the low two bytes.
    preload(32'h204, 32'hFFFF_FFFF);
    wc0 = wr_count;
    do_op("copy6", 32'h0, 32'h200, 6, 1'b0, 32'h0);
    check("copy6 tail be", {28'h0, log_be[8'(wc0 + 1)]}, 32'h3);
    check("copy6 tail word", mem[8'h81], 32'hFFFF_CCDD);

    do_op("len0", 32'h0, 32'h100, 0, 1'b0, 32'h0);

    // Misaligned source: done/err together after one cycle, busy for one cycle only.
    wc0 = wr_count;
    src_addr = 32'h2; dst_addr = 32'h100; len = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("srcmis busy", {31'h0, busy}, 32'h1);
    check("srcmis done", {31'h0, done}, 32'h1);
    check("srcmis err", {31'h0, err}, 32'h1);
    @(posedge clk); #1;
    check("srcmis busy after", {31'h0, busy}, 32'h0);
    check("srcmis writes", 32'(wr_count - wc0), 32'h0);
    do_op("dstmis", 32'h0, 32'h101, 8, 1'b0, 32'h0);

    // Reset during the second WRITE of a 16-byte copy.
    wc0 = wr_count; dc0 = done_count;
    src_addr = 32'h0; dst_addr = 32'h40; len = 16'd16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort in write", {28'h0, m_data_byteen}, 32'hF);
    reset = 1'b0;
    #1;
    check("abort byteen", {28'h0, m_data_byteen}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    for (int b = 0; b < 4; b++) model[32'h40 + 32'(b)] = model[b];
    check("abort writes", 32'(wr_count - wc0), 32'd1);
    check("abort no done", 32'(done_count - dc0), 32'd0);
    check_mem("abort memory");
    do_op("after abort", 32'h8, 32'h80, 4, 1'b0, 32'h0);

    // New start while busy must be ignored.
    wc0 = wr_count; dc0 = done_count;
    src_addr = 32'h10; dst_addr = 32'h140; len = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    src_addr = 32'h20; dst_addr = 32'h180; len = 16'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 3;
    while (!done && cycles < 100) begin @(posedge clk); #1; cycles++; end
    check("busy-start latency", 32'(cycles), 32'd5);
    check("busy-start err", {31'h0, err}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("busy-start writes", 32'(wr_count - wc0), 32'd2);
    check("busy-start dones", 32'(done_count - dc0), 32'd1);
    for (int b = 0; b < 8; b++) model[32'h140 + 32'(b)] = model[32'h10 + 32'(b)];
    check_mem("busy-start memory");

`ifdef DM_COPY_FILL_EN
    wc0 = wr_count;
    do_op("fill12", 32'h3, 32'h300, 12, 1'b1, 32'hDEAD_BEEF);
    check("fill back-to-back", 32'(log_cyc[8'(wc0 + 2)] - log_cyc[wc0[7:0]]), 32'd2);
    check("fill be", {28'h0, log_be[8'(wc0 + 2)]}, 32'hF);
`endif

    // Random copies, including overlap, tails and occasional misalignment.
    for (int k = 0; k < 24; k++) begin
      s = 32'($urandom_range(0, 127) * 4);
      d = 32'($urandom_range(0, 127) * 4);
      if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d = d + 32'($urandom_range(1, 3));
      f = 1'b0;
`ifdef DM_COPY_FILL_EN
      f = ($urandom_range(0, 3) == 0);
`endif
      do_op($sformatf("rnd%0d", k), s, d, $urandom_range(0, 40), f, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
